// File: rtl/taxi_eth_link_pkg.sv
// Shared types and widths for the 10G receive link controller.
// Holds the state encoding, bus widths and the saturating PRBS accumulator helper.
package taxi_eth_link_pkg;

  localparam int unsigned STATE_W         = 3;
  localparam int unsigned ERR_INC_W       = 7;
  localparam int unsigned LINK_DOWN_CNT_W = 16;
  localparam int unsigned PRBS_ERR_CNT_W  = 32;
  localparam int unsigned PRBS_SUM_W      = PRBS_ERR_CNT_W + 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 3'd0,
    ST_SERDES_RST  = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_WAIT_STABLE = 3'd3,
    ST_UP          = 3'd4,
    ST_PRBS        = 3'd5
  } link_state_t;

  // Timer must hold the largest terminal count of any timed state.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  function automatic logic [PRBS_ERR_CNT_W-1:0] prbs_sat_add(
    input logic [PRBS_ERR_CNT_W-1:0] acc,
    input logic [ERR_INC_W-1:0]      inc
  );
    logic [PRBS_SUM_W-1:0] sum;
    sum = {1'b0, acc} + PRBS_SUM_W'(inc);
    return sum[PRBS_ERR_CNT_W] ? '1 : sum[PRBS_ERR_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/taxi_eth_phy_10g_rx_link_ctrl.sv
// Receive link bring-up controller: SERDES reset, lock wait, stability qualification,
// link-up monitoring and a PRBS31 test mode with error accumulation.
module taxi_eth_phy_10g_rx_link_ctrl
  import taxi_eth_link_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT  = 16384,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned RST_CYCLES    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_enable,
  input  logic                       cfg_prbs31_req,
  input  logic                       rx_block_lock,
  input  logic                       rx_high_ber,
  input  logic                       rx_status,
  input  logic [ERR_INC_W-1:0]       rx_error_count,
  input  logic                       serdes_rx_reset_req,
  output logic                       serdes_rst,
  output logic                       cfg_rx_enable,
  output logic                       cfg_rx_prbs31_enable,
  output logic                       link_up,
  output logic [STATE_W-1:0]         link_state,
  output logic [LINK_DOWN_CNT_W-1:0] stat_link_down_cnt,
  output logic [PRBS_ERR_CNT_W-1:0]  stat_prbs_err_cnt
);

  localparam int unsigned TIMER_W = timer_width(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES);
  localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);

  link_state_t                r_state;
  link_state_t                w_state_next;
  logic [TIMER_W-1:0]         r_timer;
  logic                       w_timer_inc;
  logic                       w_timer_clr;
  logic                       r_serdes_rst;
  logic                       r_rx_enable;
  logic                       r_prbs_enable;
  logic                       r_link_up;
  logic [LINK_DOWN_CNT_W-1:0] r_link_down_cnt;
  logic [PRBS_ERR_CNT_W-1:0]  r_prbs_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state; cfg_enable=0 beats the PHY reset request, which beats everything else.
  always_comb begin
    w_state_next = r_state;
    w_timer_inc  = 1'b0;
    w_timer_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_enable) w_state_next = cfg_prbs31_req ? ST_PRBS : ST_SERDES_RST;
      end
      ST_SERDES_RST: begin
        if (r_timer == RST_LAST) w_state_next = ST_WAIT_LOCK;
        else                     w_timer_inc  = 1'b1;
      end
      ST_WAIT_LOCK: begin
        if (rx_block_lock)           w_state_next = ST_WAIT_STABLE;
        else if (r_timer == LOCK_LAST) w_state_next = ST_SERDES_RST;
        else                         w_timer_inc  = 1'b1;
      end
      ST_WAIT_STABLE: begin
        if (!rx_block_lock)              w_state_next = ST_WAIT_LOCK;
        else if (!rx_status)             w_timer_clr  = 1'b1;
        else if (r_timer == STABLE_LAST) w_state_next = ST_UP;
        else                             w_timer_inc  = 1'b1;
      end
      ST_UP: begin
        if (!rx_block_lock || rx_high_ber) w_state_next = ST_WAIT_LOCK;
      end
      ST_PRBS: begin
        if (!cfg_prbs31_req) w_state_next = ST_SERDES_RST;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (serdes_rx_reset_req &&
        (r_state == ST_WAIT_LOCK || r_state == ST_WAIT_STABLE || r_state == ST_UP))
      w_state_next = ST_SERDES_RST;
    if (!cfg_enable) w_state_next = ST_IDLE;
  end

  // Shared timer, cleared on every state change and on a stability glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_timer <= '0;
    else if (w_state_next != r_state || w_timer_clr) r_timer <= '0;
    else if (w_timer_inc)                           r_timer <= r_timer + TIMER_W'(1);
  end

  // Outputs decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_serdes_rst  <= 1'b0;
      r_rx_enable   <= 1'b0;
      r_prbs_enable <= 1'b0;
      r_link_up     <= 1'b0;
    end else begin
      r_serdes_rst  <= (w_state_next == ST_SERDES_RST);
      r_rx_enable   <= (w_state_next == ST_UP);
      r_prbs_enable <= (w_state_next == ST_PRBS);
      r_link_up     <= (w_state_next == ST_UP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_link_down_cnt <= '0;
      r_prbs_err_cnt  <= '0;
    end else begin
      if (r_state == ST_UP && w_state_next != ST_UP && r_link_down_cnt != '1)
        r_link_down_cnt <= r_link_down_cnt + LINK_DOWN_CNT_W'(1);
      if (w_state_next == ST_PRBS && r_state != ST_PRBS)
        r_prbs_err_cnt <= '0;
      else if (r_state == ST_PRBS)
        r_prbs_err_cnt <= prbs_sat_add(r_prbs_err_cnt, rx_error_count);
    end
  end

  assign serdes_rst           = r_serdes_rst;
  assign cfg_rx_enable        = r_rx_enable;
  assign cfg_rx_prbs31_enable = r_prbs_enable;
  assign link_up              = r_link_up;
  assign link_state           = STATE_W'(r_state);
  assign stat_link_down_cnt   = r_link_down_cnt;
  assign stat_prbs_err_cnt    = r_prbs_err_cnt;

endmodule

// File: tb/tb_taxi_eth_phy_10g_rx_link_ctrl.sv
// Directed bench for the receive link controller with a cycle-level reference model
// compared on every falling edge, plus hand-computed timing and counter expectations.
module tb_taxi_eth_phy_10g_rx_link_ctrl;
  import taxi_eth_link_pkg::*;

  localparam int P_LOCK   = 16;
  localparam int P_STABLE = 8;
  localparam int P_RST    = 4;

  logic        clk;
  logic        rst;
  logic        cfg_enable;
  logic        cfg_prbs31_req;
  logic        rx_block_lock;
  logic        rx_high_ber;
  logic        rx_status;
  logic [6:0]  rx_error_count;
  logic        serdes_rx_reset_req;
  logic        serdes_rst;
  logic        cfg_rx_enable;
  logic        cfg_rx_prbs31_enable;
  logic        link_up;
  logic [2:0]  link_state;
  logic [15:0] stat_link_down_cnt;
  logic [31:0] stat_prbs_err_cnt;

  int n_checks = 0;
  int n_err    = 0;
  bit started  = 0;

  taxi_eth_phy_10g_rx_link_ctrl #(
    .LOCK_TIMEOUT (P_LOCK),
    .STABLE_CYCLES(P_STABLE),
    .RST_CYCLES   (P_RST)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_enable          (cfg_enable),
    .cfg_prbs31_req      (cfg_prbs31_req),
    .rx_block_lock       (rx_block_lock),
    .rx_high_ber         (rx_high_ber),
    .rx_status           (rx_status),
    .rx_error_count      (rx_error_count),
    .serdes_rx_reset_req (serdes_rx_reset_req),
    .serdes_rst          (serdes_rst),
    .cfg_rx_enable       (cfg_rx_enable),
    .cfg_rx_prbs31_enable(cfg_rx_prbs31_enable),
    .link_up             (link_up),
    .link_state          (link_state),
    .stat_link_down_cnt  (stat_link_down_cnt),
    .stat_prbs_err_cnt   (stat_prbs_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state number, cycles spent in the state, consecutive good-status run.
  int     m_state = 0;
  int     m_dwell = 0;
  int     m_run   = 0;
  int     m_down  = 0;
  longint m_prbs  = 0;

  function automatic int f_next(input int s, input int dwell, input int run);
    int n;
    n = s;
    case (s)
      0: if (cfg_enable) n = cfg_prbs31_req ? 5 : 1;
      1: if (dwell + 1 >= P_RST) n = 2;
      2: if (rx_block_lock) n = 3; else if (dwell + 1 >= P_LOCK) n = 1;
      3: if (!rx_block_lock) n = 2; else if (rx_status && run + 1 >= P_STABLE) n = 4;
      4: if (!rx_block_lock || rx_high_ber) n = 2;
      5: if (!cfg_prbs31_req) n = 1;
      default: n = 0;
    endcase
    if (serdes_rx_reset_req && (s == 2 || s == 3 || s == 4)) n = 1;
    if (!cfg_enable) n = 0;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0;
      m_dwell <= 0;
      m_run   <= 0;
      m_down  <= 0;
      m_prbs  <= 0;
    end else begin
      m_state <= f_next(m_state, m_dwell, m_run);
      m_dwell <= (f_next(m_state, m_dwell, m_run) == m_state) ? m_dwell + 1 : 0;
      m_run   <= (f_next(m_state, m_dwell, m_run) == m_state && m_state == 3 && rx_status)
                 ? m_run + 1 : 0;
      if (m_state == 4 && f_next(m_state, m_dwell, m_run) != 4)
        m_down <= (m_down < 65535) ? m_down + 1 : m_down;
      if (f_next(m_state, m_dwell, m_run) == 5 && m_state != 5)
        m_prbs <= 0;
      else if (m_state == 5)
        m_prbs <= (m_prbs + longint'(rx_error_count) > 64'hFFFF_FFFF)
                  ? 64'hFFFF_FFFF : m_prbs + longint'(rx_error_count);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_link_state", 32'(link_state), 32'(m_state));
      chk("model_serdes_rst", 32'(serdes_rst), 32'(m_state == 1));
      chk("model_rx_enable", 32'(cfg_rx_enable), 32'(m_state == 4));
      chk("model_prbs_enable", 32'(cfg_rx_prbs31_enable), 32'(m_state == 5));
      chk("model_link_up", 32'(link_up), 32'(m_state == 4));
      chk("model_down_cnt", 32'(stat_link_down_cnt), 32'(m_down));
      chk("model_prbs_cnt", stat_prbs_err_cnt, 32'(m_prbs));
    end
  end

  initial begin
    int k;
    cfg_enable = 0; cfg_prbs31_req = 0; rx_block_lock = 0; rx_high_ber = 0;
    rx_status = 0; rx_error_count = '0; serdes_rx_reset_req = 0;
    rst = 0;
    #1 rst = 1;
    started = 1;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(link_state), 32'd0);
    chk("rst_counters", 32'(stat_link_down_cnt) | stat_prbs_err_cnt, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_after_rst", 32'(link_state), 32'd0);

    // Bring-up
    cfg_enable = 1;
    k = 0;
    while (!serdes_rst && k < 20) begin @(negedge clk); k++; end
    chk("pulse_start", 32'(serdes_rst), 32'd1);
    k = 0;
    while (serdes_rst && k < 50) begin @(negedge clk); k++; end
    chk("pulse_width", 32'(k), 32'd4);
    repeat (9) @(negedge clk);
    rx_block_lock = 1;
    @(negedge clk);
    chk("wait_stable_entered", 32'(link_state), 32'd3);
    rx_status = 1;
    k = 0;
    while (!link_up && k < 50) begin @(negedge clk); k++; end
    chk("stable_to_up", 32'(k), 32'd8);
    chk("rx_enable_up", 32'(cfg_rx_enable), 32'd1);

    // First link drop
    rx_high_ber = 1;
    @(negedge clk);
    rx_high_ber = 0;
    chk("drop1_state", 32'(link_state), 32'd2);
    chk("drop1_rx_enable", 32'(cfg_rx_enable), 32'd0);
    chk("drop1_cnt", 32'(stat_link_down_cnt), 32'd1);
    k = 0;
    while (!link_up && k < 50) begin @(negedge clk); k++; end
    chk("relock_up", 32'(link_up), 32'd1);

    // Second drop, then a status glitch during qualification
    rx_high_ber = 1; rx_status = 0;
    @(negedge clk);
    rx_high_ber = 0;
    chk("drop2_cnt", 32'(stat_link_down_cnt), 32'd2);
    @(negedge clk);
    chk("glitch_ws", 32'(link_state), 32'd3);
    rx_status = 1;
    repeat (4) @(negedge clk);
    rx_status = 0;
    @(negedge clk);
    rx_status = 1;
    k = 0;
    while (!link_up && k < 50) begin @(negedge clk); k++; end
    chk("glitch_recover", 32'(k), 32'd8);

    // PHY reset request from UP, then cfg_enable drop mid-pulse
    serdes_rx_reset_req = 1;
    @(negedge clk);
    serdes_rx_reset_req = 0;
    chk("req_to_serdes_rst", 32'(link_state), 32'd1);
    chk("req_down_cnt", 32'(stat_link_down_cnt), 32'd3);
    @(negedge clk);
    cfg_enable = 0;
    @(negedge clk);
    chk("disable_mid_pulse", 32'(serdes_rst), 32'd0);
    chk("disable_idle", 32'(link_state), 32'd0);

    // Lock timeout loop
    rx_block_lock = 0; rx_status = 0; cfg_enable = 1;
    k = 0;
    while (!serdes_rst && k < 20) begin @(negedge clk); k++; end
    for (int rep = 0; rep < 2; rep++) begin
      k = 0;
      while (serdes_rst && k < 100) begin @(negedge clk); k++; end
      while (!serdes_rst && k < 100) begin @(negedge clk); k++; end
      chk("timeout_period", 32'(k), 32'd20);
    end

    // Async reset between edges, mid-pulse
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_serdes_rst", 32'(serdes_rst), 32'd0);
    chk("async_state", 32'(link_state), 32'd0);
    @(negedge clk);
    rst = 0;
    #1 chk("post_rst_hold", 32'(link_state), 32'd0);

    // Simultaneous reset request and disable from UP
    rx_block_lock = 1; rx_status = 1;
    k = 0;
    while (!link_up && k < 50) begin @(negedge clk); k++; end
    chk("up_again", 32'(link_up), 32'd1);
    serdes_rx_reset_req = 1; cfg_enable = 0;
    @(negedge clk);
    serdes_rx_reset_req = 0;
    chk("req_and_disable", 32'(link_state), 32'd0);

    // PRBS mode
    cfg_prbs31_req = 1; cfg_enable = 1;
    @(negedge clk);
    chk("prbs_state", 32'(link_state), 32'd5);
    chk("prbs_enable", 32'(cfg_rx_prbs31_enable), 32'd1);
    rx_error_count = 7'd3;
    repeat (10) @(negedge clk);
    rx_error_count = '0;
    chk("prbs_30", stat_prbs_err_cnt, 32'd30);
    rx_error_count = 7'd127;
    repeat (3) @(negedge clk);
    rx_error_count = '0;
    chk("prbs_411", stat_prbs_err_cnt, 32'd411);
    chk("sat_add_top", prbs_sat_add(32'hFFFF_FFF0, 7'd127), 32'hFFFF_FFFF);
    chk("sat_add_below", prbs_sat_add(32'hFFFF_FF00, 7'd127), 32'hFFFF_FF7F);
    cfg_prbs31_req = 0;
    @(negedge clk);
    chk("prbs_exit", 32'(link_state), 32'd1);
    chk("prbs_cnt_held", stat_prbs_err_cnt, 32'd411);
    cfg_prbs31_req = 1;
    k = 0;
    while (!link_up && k < 50) begin @(negedge clk); k++; end
    chk("prbs_req_ignored", 32'(link_up), 32'd1);
    cfg_enable = 0;
    @(negedge clk);
    cfg_enable = 1;
    @(negedge clk);
    chk("prbs_reentry_clear", stat_prbs_err_cnt, 32'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
